vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Parametrised successor to the fixed 640x480 VGA controller. Generates pixel-enable, pixel coordinates, sync, blank and line/frame event strobes for any resolution and porch set. Adds a configurable pixel-clock divider, sync polarity, and a sync/blank delay pipeline that aligns the timing outputs with a multi-cycle pixel renderer. Sits between the system clock and the game video generator, replacing the toggle-divider and controller pair.

Parameters:
HACTIVE, 640, visible pixels per line
HFP, 16, horizontal front porch (pixels)
HSYN, 96, horizontal sync width (pixels)
HBP, 48, horizontal back porch (pixels)
VACTIVE, 480, visible lines per frame
VFP, 10, vertical front porch (lines)
VSYN, 2, vertical sync width (lines)
VBP, 33, vertical back porch (lines)
DIV, 2, clk cycles per pixel, >=1
HS_POL, 0, active level of hsync
VS_POL, 0, active level of vsync
PIPE_DELAY, 0, pixel ticks of delay on hsync/vsync/blank_b, 0..15
CW, 11, counter width; must hold HMAX-1 and VMAX-1

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high
pix_tick  out  1  one-clk pulse, once per pixel
x  out  CW  horizontal counter, 0..HMAX-1
y  out  CW  vertical counter, 0..VMAX-1
active  out  1  x<HACTIVE and y<VACTIVE, undelayed
hsync  out  1  horizontal sync, delayed PIPE_DELAY ticks
vsync  out  1  vertical sync, delayed PIPE_DELAY ticks
blank_b  out  1  high while visible, delayed PIPE_DELAY ticks
sync_b  out  1  constant 0
line_start  out  1  pulses with pix_tick when x==0
frame_start  out  1  pulses with pix_tick when x==0 and y==0
vblank_start  out  1  pulses with pix_tick when x==0 and y==VACTIVE

Behaviour:
- Reset is asynchronous, active-high; clock is clk. All registers update on posedge clk.
- HMAX=HACTIVE+HFP+HSYN+HBP; VMAX=VACTIVE+VFP+VSYN+VBP. Line order: active, front porch, sync, back porch.
- Divider: div_cnt resets to 0 and counts 0..DIV-1 every clk, wrapping. pix_tick = (div_cnt==DIV-1), combinational from the register. For DIV=1, pix_tick is constantly 1 out of reset.
- Counters: x and y reset to 0 and change only on clk edges where pix_tick=1.
  - x increments; when x==HMAX-1, x wraps to 0 and y increments.
  - When y==VMAX-1 and x==HMAX-1, both wrap to 0.
  - x never equals HMAX and y never equals VMAX.
- Decode on the current x and y:
  - hs_raw = (x>=HACTIVE+HFP and x<HACTIVE+HFP+HSYN)
  - vs_raw = (y>=VACTIVE+VFP and y<VACTIVE+VFP+VSYN)
  - vis = active
- hsync = HS_POL ? hs_d : ~hs_d. vsync uses VS_POL the same way.
- Delay pipeline:
  - PIPE_DELAY=0: hs_d, vs_d and blank_b are the combinational decode of the counters.
  - PIPE_DELAY=N>0: an N-stage shift register that advances only on pix_tick. It resets to hs_d=0, vs_d=0, blank_b=0, so reset drives inactive sync levels and blanking.
- The line_start, frame_start and vblank_start strobes are combinational and gated by pix_tick, so each is one clk wide.
- Reset mid-frame: all counters, the divider and the pipeline return to reset values immediately, with no completion of the current line.
- Register outputs x, y, div_cnt and the pipeline; no combinational path from reset to the strobes other than through registers.

Optional Feature:
- Macro VGA_FRAME_COUNT_EN.
- Defined: adds output frame_cnt (16 bits, out). It resets to 0, increments on each frame_start, and wraps 0xFFFF->0. The game logic uses it for speed ramping.
- Undefined: the port and its counter are absent. All other behaviour is identical.

Test Plan:
1. Defaults, DIV=2, release reset -> pix_tick every 2nd clk; x counts 0..799 and wraps to 0 with y 0->1; line_start once per 800 ticks.
2. Defaults, PIPE_DELAY=0 -> hsync low exactly for x=656..751; vsync low exactly for y=490..491; blank_b=1 only for x<640 and y<480.
3. Full frame -> frame_start pulses once per 420000 ticks (800x525); vblank_start at x=0, y=480; y never reaches 525.
4. PIPE_DELAY=3 -> hsync falls 3 ticks after x becomes 656; blank_b falls 3 ticks after x becomes 640; all pipelined outputs inactive for the first 3 ticks after reset.
5. DIV=1, HS_POL=1, small mode (HACTIVE=8, HFP=2, HSYN=2, HBP=2) -> pix_tick constant 1; hsync high for x=10..11; line period 14 clk.
6. Assert reset at x=300, y=200 -> x, y and div_cnt are 0 in the same cycle, blank_b=1 (PIPE_DELAY=0); with VGA_FRAME_COUNT_EN, frame_cnt=0 and reaches 1 after one full frame.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Parametrised VGA timing generator. Divides clk down to a pixel tick and
// runs the x/y raster counters on it. Decodes sync, blank and the line/frame
// event strobes, with an optional per-pixel delay pipeline on sync and blank
// so they line up with a multi-cycle pixel renderer.
//
// Ports:
//   clk, reset    system clock, asynchronous active-high reset
//   pix_tick      one-clk pulse per pixel
//   x, y          raster position (0..HMAX-1, 0..VMAX-1)
//   active        visible-area flag, undelayed
//   hsync, vsync  sync outputs with programmable polarity, delayed PIPE_DELAY ticks
//   blank_b       high while visible, delayed PIPE_DELAY ticks
//   sync_b        tied low
//   line_start, frame_start, vblank_start   one-clk event strobes
//   frame_cnt     16-bit frame counter, present only with VGA_FRAME_COUNT_EN
//
// Build option: define VGA_FRAME_COUNT_EN to add the frame_cnt output.
module vga_timing_gen #(
    parameter int HACTIVE    = 640,
    parameter int HFP        = 16,
    parameter int HSYN       = 96,
    parameter int HBP        = 48,
    parameter int VACTIVE    = 480,
    parameter int VFP        = 10,
    parameter int VSYN       = 2,
    parameter int VBP        = 33,
    parameter int DIV        = 2,
    parameter int HS_POL     = 0,
    parameter int VS_POL     = 0,
    parameter int PIPE_DELAY = 0,
    parameter int CW         = 11
) (
    input  logic          clk,
    input  logic          reset,
    output logic          pix_tick,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          active,
    output logic          hsync,
    output logic          vsync,
    output logic          blank_b,
    output logic          sync_b,
    output logic          line_start,
    output logic          frame_start,
`ifdef VGA_FRAME_COUNT_EN
    output logic          vblank_start,
    output logic [15:0]   frame_cnt
`else
    output logic          vblank_start
`endif
);

    localparam int HMAX = HACTIVE + HFP + HSYN + HBP;
    localparam int VMAX = VACTIVE + VFP + VSYN + VBP;
    localparam int DW   = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [CW-1:0] X_LAST   = CW'(HMAX - 1);
    localparam logic [CW-1:0] Y_LAST   = CW'(VMAX - 1);
    localparam logic [CW-1:0] H_VIS    = CW'(HACTIVE);
    localparam logic [CW-1:0] V_VIS    = CW'(VACTIVE);
    localparam logic [CW-1:0] HS_START = CW'(HACTIVE + HFP);
    localparam logic [CW-1:0] HS_END   = CW'(HACTIVE + HFP + HSYN);
    localparam logic [CW-1:0] VS_START = CW'(VACTIVE + VFP);
    localparam logic [CW-1:0] VS_END   = CW'(VACTIVE + VFP + VSYN);

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] y_q, y_d;

    logic hs_raw, vs_raw, vis_raw;
    logic hs_dly, vs_dly, vis_dly;

    // With DIV=1 DIV_LAST is 0, so the divider sits at 0 and the tick is constant.
    assign pix_tick = (div_cnt_q == DIV_LAST);

    always_comb begin
        div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DW'(1);
        x_d = x_q;
        y_d = y_q;
        if (pix_tick) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + CW'(1);
            end else begin
                x_d = x_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_q <= '0;
            x_q       <= '0;
            y_q       <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            x_q       <= x_d;
            y_q       <= y_d;
        end
    end

    assign hs_raw  = (x_q >= HS_START) && (x_q < HS_END);
    assign vs_raw  = (y_q >= VS_START) && (y_q < VS_END);
    assign vis_raw = (x_q < H_VIS) && (y_q < V_VIS);

    generate
        if (PIPE_DELAY == 0) begin : g_no_dly
            assign hs_dly  = hs_raw;
            assign vs_dly  = vs_raw;
            assign vis_dly = vis_raw;
        end else begin : g_dly
            // Bit 0 takes the fresh decode; the MSB is the oldest sample.
            logic [PIPE_DELAY-1:0] hs_pipe_q,  hs_pipe_d;
            logic [PIPE_DELAY-1:0] vs_pipe_q,  vs_pipe_d;
            logic [PIPE_DELAY-1:0] vis_pipe_q, vis_pipe_d;

            always_comb begin
                hs_pipe_d  = hs_pipe_q;
                vs_pipe_d  = vs_pipe_q;
                vis_pipe_d = vis_pipe_q;
                if (pix_tick) begin
                    hs_pipe_d  = (hs_pipe_q  << 1) | PIPE_DELAY'(hs_raw);
                    vs_pipe_d  = (vs_pipe_q  << 1) | PIPE_DELAY'(vs_raw);
                    vis_pipe_d = (vis_pipe_q << 1) | PIPE_DELAY'(vis_raw);
                end
            end

            // Reset to zero: sync inactive and blanking asserted until the pipe fills.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    hs_pipe_q  <= '0;
                    vs_pipe_q  <= '0;
                    vis_pipe_q <= '0;
                end else begin
                    hs_pipe_q  <= hs_pipe_d;
                    vs_pipe_q  <= vs_pipe_d;
                    vis_pipe_q <= vis_pipe_d;
                end
            end

            assign hs_dly  = hs_pipe_q[PIPE_DELAY-1];
            assign vs_dly  = vs_pipe_q[PIPE_DELAY-1];
            assign vis_dly = vis_pipe_q[PIPE_DELAY-1];
        end
    endgenerate

    assign x            = x_q;
    assign y            = y_q;
    assign active       = vis_raw;
    assign hsync        = (HS_POL != 0) ? hs_dly : ~hs_dly;
    assign vsync        = (VS_POL != 0) ? vs_dly : ~vs_dly;
    assign blank_b      = vis_dly;
    assign sync_b       = 1'b0;
    assign line_start   = pix_tick && (x_q == '0);
    assign frame_start  = line_start && (y_q == '0);
    assign vblank_start = line_start && (y_q == V_VIS);

`ifdef VGA_FRAME_COUNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_start ? frame_cnt_q + 16'd1 : frame_cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
// Three instances share clk/reset:
//   a: default horizontal timing, short vertical (4/1/2/1 -> 8 lines), DIV=2, no delay
//   b: same timing as a with PIPE_DELAY=3
//   c: tiny mode 8/2/2/2 x 4/1/1/1, DIV=1, HS_POL=1
// Expected values come from the elapsed clk count since reset release.
module tb_vga_timing_gen;

    logic clk;
    logic reset;

    logic        a_pix_tick, a_active, a_hsync, a_vsync, a_blank_b, a_sync_b;
    logic        a_line_start, a_frame_start, a_vblank_start;
    logic [10:0] a_x, a_y;
    logic        b_pix_tick, b_active, b_hsync, b_vsync, b_blank_b, b_sync_b;
    logic        b_line_start, b_frame_start, b_vblank_start;
    logic [10:0] b_x, b_y;
    logic        c_pix_tick, c_active, c_hsync, c_vsync, c_blank_b, c_sync_b;
    logic        c_line_start, c_frame_start, c_vblank_start;
    logic [10:0] c_x, c_y;
`ifdef VGA_FRAME_COUNT_EN
    logic [15:0] a_frame_cnt, b_frame_cnt, c_frame_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    vga_timing_gen #(
        .VACTIVE(4), .VFP(1), .VSYN(2), .VBP(1), .DIV(2), .PIPE_DELAY(0)
    ) u_a (
        .clk(clk), .reset(reset), .pix_tick(a_pix_tick), .x(a_x), .y(a_y),
        .active(a_active), .hsync(a_hsync), .vsync(a_vsync), .blank_b(a_blank_b),
        .sync_b(a_sync_b), .line_start(a_line_start), .frame_start(a_frame_start),
`ifdef VGA_FRAME_COUNT_EN
        .frame_cnt(a_frame_cnt),
`endif
        .vblank_start(a_vblank_start)
    );

    vga_timing_gen #(
        .VACTIVE(4), .VFP(1), .VSYN(2), .VBP(1), .DIV(2), .PIPE_DELAY(3)
    ) u_b (
        .clk(clk), .reset(reset), .pix_tick(b_pix_tick), .x(b_x), .y(b_y),
        .active(b_active), .hsync(b_hsync), .vsync(b_vsync), .blank_b(b_blank_b),
        .sync_b(b_sync_b), .line_start(b_line_start), .frame_start(b_frame_start),
`ifdef VGA_FRAME_COUNT_EN
        .frame_cnt(b_frame_cnt),
`endif
        .vblank_start(b_vblank_start)
    );

    vga_timing_gen #(
        .HACTIVE(8), .HFP(2), .HSYN(2), .HBP(2),
        .VACTIVE(4), .VFP(1), .VSYN(1), .VBP(1),
        .DIV(1), .HS_POL(1), .VS_POL(0), .PIPE_DELAY(0)
    ) u_c (
        .clk(clk), .reset(reset), .pix_tick(c_pix_tick), .x(c_x), .y(c_y),
        .active(c_active), .hsync(c_hsync), .vsync(c_vsync), .blank_b(c_blank_b),
        .sync_b(c_sync_b), .line_start(c_line_start), .frame_start(c_frame_start),
`ifdef VGA_FRAME_COUNT_EN
        .frame_cnt(c_frame_cnt),
`endif
        .vblank_start(c_vblank_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Raster position after t pixel ticks from reset.
    function automatic void pos(input int t, input int hmax, input int vmax,
                                output int xe, output int ye);
        xe = t % hmax;
        ye = (t / hmax) % vmax;
    endfunction

    initial begin
        int  ta, pt, xa, ya, xd, yd, xc, yc;
        bit  found;

        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_a_x", a_x, 0);
        check("rst_a_blank_b", a_blank_b, 1);
        check("rst_b_blank_b", b_blank_b, 0);
        check("rst_b_hsync", b_hsync, 1);
        reset = 1'b0;
        #1;

        // k = number of clk posedges since reset release.
        for (int k = 0; k < 12820; k++) begin
            ta = k / 2;
            pt = (k % 2 == 1);
            pos(ta, 800, 8, xa, ya);
            check("a_pix_tick", a_pix_tick, pt);
            check("a_x", a_x, xa);
            check("a_y", a_y, ya);
            check("a_active", a_active, (xa < 640) && (ya < 4));
            check("a_hsync", a_hsync, !((xa >= 656) && (xa < 752)));
            check("a_vsync", a_vsync, !((ya >= 5) && (ya < 7)));
            check("a_blank_b", a_blank_b, (xa < 640) && (ya < 4));
            check("a_sync_b", a_sync_b, 0);
            check("a_line_start", a_line_start, pt && (xa == 0));
            check("a_frame_start", a_frame_start, pt && (xa == 0) && (ya == 0));
            check("a_vblank_start", a_vblank_start, pt && (xa == 0) && (ya == 4));
`ifdef VGA_FRAME_COUNT_EN
            check("a_frame_cnt", a_frame_cnt, (ta + 6399) / 6400);
`endif
            // b: counters undelayed, sync/blank show the decode from 3 ticks earlier
            check("b_x", b_x, xa);
            check("b_y", b_y, ya);
            check("b_active", b_active, (xa < 640) && (ya < 4));
            if (ta >= 3) begin
                pos(ta - 3, 800, 8, xd, yd);
                check("b_hsync", b_hsync, !((xd >= 656) && (xd < 752)));
                check("b_vsync", b_vsync, !((yd >= 5) && (yd < 7)));
                check("b_blank_b", b_blank_b, (xd < 640) && (yd < 4));
            end else begin
                check("b_hsync_init", b_hsync, 1);
                check("b_vsync_init", b_vsync, 1);
                check("b_blank_b_init", b_blank_b, 0);
            end
            // c: DIV=1 so every clk is a tick
            pos(k, 14, 7, xc, yc);
            check("c_pix_tick", c_pix_tick, 1);
            check("c_x", c_x, xc);
            check("c_y", c_y, yc);
            check("c_hsync", c_hsync, (xc >= 10) && (xc < 12));
            check("c_vsync", c_vsync, !(yc == 5));
            check("c_blank_b", c_blank_b, (xc < 8) && (yc < 4));
            check("c_line_start", c_line_start, xc == 0);
            check("c_frame_start", c_frame_start, (xc == 0) && (yc == 0));
            check("c_vblank_start", c_vblank_start, (xc == 0) && (yc == 4));
            @(posedge clk);
            #1;
        end

        // Mid-frame reset on a at x=300, y=2.
        found = 1'b0;
        for (int i = 0; i < 20000 && !found; i++) begin
            @(posedge clk);
            #1;
            if (a_x == 11'd300 && a_y == 11'd2) found = 1'b1;
        end
        check("reset_wait_found", found, 1);
        reset = 1'b1;
        #1;
        check("midrst_a_x", a_x, 0);
        check("midrst_a_y", a_y, 0);
        check("midrst_a_pix_tick", a_pix_tick, 0);
        check("midrst_a_blank_b", a_blank_b, 1);
        check("midrst_b_blank_b", b_blank_b, 0);
        check("midrst_b_hsync", b_hsync, 1);
        check("midrst_c_x", c_x, 0);
`ifdef VGA_FRAME_COUNT_EN
        check("midrst_a_frame_cnt", a_frame_cnt, 0);
`endif
        #2;
        reset = 1'b0;
        repeat (12800) @(posedge clk);
        #1;
        check("frame_a_x", a_x, 0);
        check("frame_a_y", a_y, 0);
        check("frame_a_pix_tick", a_pix_tick, 0);
`ifdef VGA_FRAME_COUNT_EN
        check("frame_a_frame_cnt", a_frame_cnt, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
